clk_step_ctrl: RTL and testbench

- Parametrised successor to the fixed cnt[21] clock divider that feeds the single-cycle CPU.
- Generates a one-cycle CPU clock enable, cpu_en, at a runtime-selectable rate, plus a matching square-wave cpu_clk for the board LEDs.
- Adds pause and single-step modes. Single-step is driven by a debounced push-button, so the 7-segment display can be inspected one instruction at a time.
- Sits between the board clock/buttons and sccomp_dataflow; all logic runs on the board clock.

---
 rtl/clk_step_ctrl.sv | 150 +++++++++++++++
 tb/tb_clk_step_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_step_ctrl.sv
// CPU clock-enable generator for the single-cycle CPU: a free-running divider with a selectable
// rate, plus pause and debounced single-step modes. Everything runs on the board clock.
module clk_step_ctrl #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned DEB_W  = 16,
  parameter int unsigned TCNT_W = 32
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic              mode,
  input  logic              pause,
  input  logic              step_btn,
  output logic              cpu_en,
  output logic              cpu_clk,
  output logic [TCNT_W-1:0] tick_cnt,
  output logic [1:0]        state
);

  localparam int unsigned DMax = CNT_W - 1;

  typedef enum logic [1:0] {
    StRun  = 2'b00,
    StHalt = 2'b01,
    StStep = 2'b10
  } state_e;

  logic [SEL_W-1:0]  sel_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  run_mask;
  logic [CNT_W-1:0]  half_init;
  logic [CNT_W-1:0]  hcnt_q;
  logic [31:0]       d_eff;
  logic              run_hit;

  logic              sync1_q;
  logic              sync2_q;
  logic              deb_q;
  logic              step_req_q;
  logic [DEB_W-1:0]  deb_cnt_q;

  state_e            state_q;
  logic              cpu_en_q;
  logic              cpu_en_d;
  logic              cpu_clk_q;
  logic [TCNT_W-1:0] tick_q;

  // run_mask holds d+1 low ones; half_init = 2^d - 1 extra high cycles after the rising one.
  always_comb begin
    d_eff     = (32'(sel_q) > DMax) ? DMax : 32'(sel_q);
    run_mask  = {CNT_W{1'b1}} >> (DMax - d_eff);
    half_init = run_mask >> 1;
    run_hit   = (cnt_q & run_mask) == run_mask;
    cpu_en_d  = ((state_q == StRun) && run_hit) || ((state_q == StHalt) && step_req_q);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sel_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= div_sel;
      if (div_sel != sel_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_cnt_q  <= '0;
      step_req_q <= 1'b0;
    end else begin
      sync1_q    <= step_btn;
      sync2_q    <= sync1_q;
      step_req_q <= 1'b0;
      if (sync2_q != deb_q) begin
        if (deb_cnt_q == {DEB_W{1'b1}}) begin
          deb_q      <= sync2_q;
          deb_cnt_q  <= '0;
          step_req_q <= sync2_q;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= StHalt;
      cpu_en_q <= 1'b0;
    end else begin
      cpu_en_q <= cpu_en_d;
      unique case (state_q)
        StRun: begin
          if (mode || pause) state_q <= StHalt;
        end
        StHalt: begin
          if (step_req_q) begin
            state_q <= StStep;
          end else if (!mode && !pause) begin
            state_q <= StRun;
          end
        end
        StStep:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // A fresh enable reloads the high phase even if cpu_clk is already high.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cpu_clk_q <= 1'b0;
      hcnt_q    <= '0;
    end else if (cpu_en_d) begin
      cpu_clk_q <= 1'b1;
      hcnt_q    <= half_init;
    end else if (cpu_clk_q) begin
      if (hcnt_q == '0) begin
        cpu_clk_q <= 1'b0;
      end else begin
        hcnt_q <= hcnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TCNT_W'(cpu_en_q);
    end
  end

  assign cpu_en   = cpu_en_q;
  assign cpu_clk  = cpu_clk_q;
  assign tick_cnt = tick_q;
  assign state    = state_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Randomised bench for clk_step_ctrl; every cycle is compared against a behavioural model that
// works from pulse periods, sample windows and tick arithmetic.
module tb_clk_step_ctrl;

  localparam int CNT_W  = 8;
  localparam int SEL_W  = 5;
  localparam int DEB_W  = 4;
  localparam int TCNT_W = 4;
  localparam int DebN   = 1 << DEB_W;

  logic              clock = 1'b0;
  logic              resetn;
  logic [SEL_W-1:0]  div_sel;
  logic              mode;
  logic              pause;
  logic              step_btn;
  logic              cpu_en;
  logic              cpu_clk;
  logic [TCNT_W-1:0] tick_cnt;
  logic [1:0]        state;

  clk_step_ctrl #(
    .CNT_W (CNT_W),
    .SEL_W (SEL_W),
    .DEB_W (DEB_W),
    .TCNT_W(TCNT_W)
  ) u_dut (
    .clock   (clock),
    .resetn  (resetn),
    .div_sel (div_sel),
    .mode    (mode),
    .pause   (pause),
    .step_btn(step_btn),
    .cpu_en  (cpu_en),
    .cpu_clk (cpu_clk),
    .tick_cnt(tick_cnt),
    .state   (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_pulse = 0;
  int last_gap   = 0;
  int win_pulses = 0;

  // Reference model state. States: 0 run, 1 halt, 2 step.
  int m_sel = 0, m_cnt = 0, m_state = 1, m_tick = 0, m_left = 0;
  bit m_s1 = 0, m_s2 = 0, m_deb = 0, m_req = 0, m_en = 0;
  bit hist[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_edge();
    int  d, p, st_n;
    bit  hit, en_n, all_diff;
    if (!resetn) begin
      m_sel = 0; m_cnt = 0; m_state = 1; m_tick = 0; m_left = 0;
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_req = 0; m_en = 0;
      hist.delete();
      return;
    end
    d    = (m_sel > CNT_W - 1) ? CNT_W - 1 : m_sel;
    p    = 1 << (d + 1);
    hit  = (m_cnt % p) == p - 1;
    en_n = (m_state == 0 && hit) || (m_state == 1 && m_req);
    case (m_state)
      0:       st_n = (mode || pause) ? 1 : 0;
      1:       st_n = m_req ? 2 : ((!mode && !pause) ? 0 : 1);
      default: st_n = 1;
    endcase
    m_tick = (m_tick + int'(m_en)) % (1 << TCNT_W);
    if (en_n) m_left = p / 2;
    else if (m_left > 0) m_left--;
    // Debounced level flips once the last DebN synchronised samples all disagree with it.
    m_req = 0;
    hist.push_back(m_s2);
    if (hist.size() > DebN) void'(hist.pop_front());
    if (hist.size() == DebN) begin
      all_diff = 1;
      foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
      if (all_diff) begin
        m_deb = ~m_deb;
        m_req = m_deb;
        hist.delete();
      end
    end
    if (int'(div_sel) != m_sel) m_cnt = 0;
    else m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_sel   = int'(div_sel);
    m_s2    = m_s1;
    m_s1    = step_btn;
    m_en    = en_n;
    m_state = st_n;
  endtask

  task automatic step_clk();
    @(posedge clock);
    model_edge();
    #1;
    cyc++;
    if (cpu_en === 1'b1) begin
      last_gap   = cyc - last_pulse;
      last_pulse = cyc;
      win_pulses++;
    end
    check("cpu_en", 32'(cpu_en), 32'(m_en));
    check("cpu_clk", 32'(cpu_clk), 32'(m_left > 0));
    check("tick_cnt", 32'(tick_cnt), 32'(m_tick));
    check("state", 32'(state), 32'(m_state));
  endtask

  task automatic run_pulses(input int n, input int gap, input string tag, input int budget);
    int cnt = 0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      step_clk();
      if (cpu_en === 1'b1) begin
        cnt++;
        if (cnt > 1) check(tag, 32'(last_gap), 32'(gap));
      end
    end
    if (cnt < n) check({tag, "_timeout"}, 32'(cnt), 32'(n));
  endtask

  task automatic hold_btn(input bit lvl, input int n);
    step_btn = lvl;
    repeat (n) step_clk();
  endtask

  initial begin
    bit found;
    resetn = 1'b0; div_sel = '0; mode = 1'b0; pause = 1'b0; step_btn = 1'b0;
    repeat (3) step_clk();
    check("rst_state", 32'(state), 32'd1);
    check("rst_tick", 32'(tick_cnt), 32'd0);
    check("rst_en", 32'(cpu_en), 32'd0);

    // Free run at d=2
    resetn = 1'b1; div_sel = 5'd2;
    run_pulses(10, 8, "run_gap", 200);
    step_clk();
    check("tick10", 32'(tick_cnt), 32'd10);

    // Rate change mid-period
    repeat ($urandom_range(1, 6)) step_clk();
    div_sel = 5'd0;
    run_pulses(6, 2, "fast_gap", 40);

    // Single step with a bouncing button
    mode = 1'b1;
    repeat (4) step_clk();
    win_pulses = 0;
    for (int i = 0; i < 5; i++) hold_btn(~step_btn, $urandom_range(1, 2));
    for (int i = 0; i < 40; i++) begin
      step_clk();
      if (cpu_en === 1'b1) check("step_state", 32'(state), 32'd2);
    end
    check("bounce_pulses", 32'(win_pulses), 32'd1);
    hold_btn(1'b0, 40);
    win_pulses = 0;
    hold_btn(1'b1, 40);
    hold_btn(1'b0, 40);
    check("clean_pulses", 32'(win_pulses), 32'd1);

    // Button press during RUN is discarded
    mode = 1'b0; div_sel = 5'd1;
    run_pulses(2, 4, "run4_gap", 40);
    win_pulses = 0;
    hold_btn(1'b1, 40);
    hold_btn(1'b0, 40);
    check("discard_cnt", 32'(win_pulses), 32'd20);

    // Pause and resume
    repeat ($urandom_range(0, 3)) step_clk();
    win_pulses = 0;
    pause = 1'b1;
    repeat (30) step_clk();
    check("pause_leak", 32'(win_pulses <= 1), 32'd1);
    win_pulses = 0;
    repeat (20) step_clk();
    check("pause_quiet", 32'(win_pulses), 32'd0);
    pause = 1'b0;
    run_pulses(3, 4, "resume_gap", 40);

    // step_req coinciding with mode 1->0 while halted
    mode = 1'b1;
    repeat (4) step_clk();
    step_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_req && m_state == 1) begin
        found = 1;
        mode = 1'b0;
        step_clk();
        check("simul_step", 32'(state), 32'd2);
        step_clk();
        check("simul_halt", 32'(state), 32'd1);
        step_clk();
        check("simul_run", 32'(state), 32'd0);
      end else begin
        step_clk();
      end
    end
    if (!found) check("simul_timeout", 32'd0, 32'd1);
    hold_btn(1'b0, 30);

    // Reset in the middle of a STEP
    mode = 1'b1;
    repeat (4) step_clk();
    step_btn = 1'b1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step_clk();
      if (state === 2'd2) found = 1;
    end
    if (!found) check("step_timeout", 32'd0, 32'd1);
    resetn = 1'b0; step_btn = 1'b0;
    step_clk();
    check("rst_step_en", 32'(cpu_en), 32'd0);
    check("rst_step_clk", 32'(cpu_clk), 32'd0);
    check("rst_step_tick", 32'(tick_cnt), 32'd0);
    check("rst_step_state", 32'(state), 32'd1);

    // Tick counter wrap after 17 pulses
    resetn = 1'b1; mode = 1'b0; div_sel = 5'd0;
    run_pulses(17, 2, "wrap_gap", 80);
    step_clk();
    check("tick_wrap", 32'(tick_cnt), 32'd1);

    // Divide select clamped to CNT_W-1
    div_sel = 5'd31;
    run_pulses(3, 256, "clamp_gap", 900);

    // Random mix of modes, rates, button activity and resets
    for (int i = 0; i < 150; i++) begin
      mode     = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 4) == 0);
      div_sel  = 5'($urandom_range(0, 3));
      step_btn = 1'($urandom_range(0, 1));
      resetn   = ($urandom_range(0, 40) != 0);
      repeat ($urandom_range(1, 30)) step_clk();
      resetn = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
